note_lane_scroller: RTL and testbench
=====================================

Name: note_lane_scroller

Overview:
- Sequential successor of the combinational note bitmap drawer for the LED matrix rhythm game.
- Holds a lane of note slots and a pixel-scroll offset. Accepts new notes through a valid/ready handshake and scrolls them toward column 0 on each tick pulse.
- Clears hits at the judge slot and flags misses.
- Renders one 7-row note band on demand, one row per request, for the matrix driver.

Parameters:
- COLS, 64, visible columns; pixel c occupies row_bitmap[3c+2:3c], c=0 leftmost.
- SLOTS, 10, lane slots of 7 px each; requires SLOTS*7 >= COLS+6.
- SW, 4, width of slot index arithmetic; must satisfy 2^SW > SLOTS.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle scroll step strobe
- note_valid  in  1  new note offered
- note_type  in  2  00 empty, 01 red, 10 blue, 11 gold
- note_ready  out  1  pending buffer free
- hit_valid  in  1  player strike at judge slot
- hit_ack  out  1  registered pulse, strike consumed a note
- hit_type  out  2  type of the consumed note (valid with hit_ack)
- miss_pulse  out  1  registered pulse, non-empty note scrolled out unhit
- judge_type  out  2  current type in slot 0
- row_req  in  1  render request
- row_sel  in  3  row 0..6 of the band
- row_valid  out  1  row_bitmap valid
- row_bitmap  out  3*COLS  rendered RGB row

Behaviour:
- Reset (async, rst_n=0) clears:
  - All slots to 00, offset to 0, and the pending buffer.
  - hit_ack, hit_type, miss_pulse, row_valid and row_bitmap all go to 0.
  - note_ready=1 once reset is released.
- Handshake:
  - One-entry pending buffer; note_ready = !pend_v.
  - Transfer occurs when note_valid && note_ready; pend_v is then set on the next edge.
- Scroll:
  - On tick, offset increments 0..6. When offset is 6, tick wraps it to 0 and triggers a shift.
  - Shift: slot[k] <= slot[k+1] for k < SLOTS-1.
  - slot[SLOTS-1] <= pend_v ? pend_type : 00. Consuming pend clears pend_v on the same edge.
  - A transfer in the same cycle as a shift lands in pend and does not bypass to the slot.
- Hit:
  - hit_valid with slot[0] != 00 gives hit_ack=1 and hit_type=slot[0] on the next cycle.
  - slot[0] is cleared, unless a shift overwrites it in the same cycle.
  - hit_valid with slot[0]=00 gives hit_ack=0 and no state change.
- Miss: a shift discarding a non-empty slot[0] with no same-cycle hit gives miss_pulse=1 on the next cycle.
- Hit and shift in the same cycle: the hit is credited to the outgoing slot[0], with no miss.
- judge_type = slot[0], combinational from state.
- Render:
  - Latency 1 cycle: row_req registers row_bitmap and sets row_valid=1 for 1 cycle.
  - The render uses the state sampled on the request edge, before any same-cycle update.
  - row_bitmap holds its value between requests.
  - For each column c: x = c + offset, s = x / 7, p = x % 7, t = slot[s].
  - Pixel is 000 if t=00. Otherwise the pixel comes from the sprite:
    - Border 111 at: row 0 p2-4; row 1 p1,p5; rows 2-4 p0,p6; row 5 p1,p5; row 6 p2-4.
    - Interior is the type colour (red 100, blue 011, gold 110) at: row 1 p2-4; rows 2-4 p1-5; row 5 p2-4.
    - All other pixels are 000.
  - row_sel of 7 renders all zeros with row_valid still pulsed.
- Reset mid-operation aborts everything immediately, including a render in flight, so row_valid=0.

Test Plan:
- Reset, then a request for row 3 → row_valid=1 one cycle later, row_bitmap=0, note_ready=1, judge_type=00.
- Offer note 01, then 7 ticks → slot[9]=01. Request row 3 at offset 0 → pixels 63..62 at slot 9 start column 63 give bits[191:189]=111 (p0 border) for column 63, and all other columns 0.
- Offer notes 10 and 01 back to back:
  - First is accepted, note_ready drops.
  - Second is held until the next shift consumes pend.
  - Exactly 2 shifts place 10 in slot 8 and 01 in slot 9.
- Scroll a red note to slot 0, then raise hit_valid → next cycle hit_ack=1, hit_type=01, judge_type=00. A further shift gives miss_pulse=0.
- Scroll a blue note to slot 0 with no hit, then a shift → miss_pulse=1 for exactly 1 cycle.
- Simultaneous hit_valid and wrapping tick with slot[0]=11 → hit_ack=1, hit_type=11, miss_pulse=0.
- Assert rst_n low mid-scroll → all outputs 0 asynchronously, with no edge needed.

Source files
------------

// File: rtl/note_lane_scroller.sv
// Note lane for the LED matrix rhythm game: scrolls queued notes toward the judge
// slot, resolves hits and misses, and renders one row of the 7-row note band per request.
module note_lane_scroller #(
  parameter int COLS  = 64,
  parameter int SLOTS = 10,
  parameter int SW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              note_valid,
  input  logic [1:0]        note_type,
  output logic              note_ready,
  input  logic              hit_valid,
  output logic              hit_ack,
  output logic [1:0]        hit_type,
  output logic              miss_pulse,
  output logic [1:0]        judge_type,
  input  logic              row_req,
  input  logic [2:0]        row_sel,
  output logic              row_valid,
  output logic [3*COLS-1:0] row_bitmap
);

  localparam logic [2:0] OFF_MAX = 3'd6;

  logic [1:0]        slot_q [SLOTS];
  logic [1:0]        slot_d [SLOTS];
  logic [2:0]        off_q, off_d;
  logic              pend_v_q, pend_v_d;
  logic [1:0]        pend_type_q, pend_type_d;
  logic              hit_ack_q, hit_ack_d;
  logic [1:0]        hit_type_q, hit_type_d;
  logic              miss_q, miss_d;
  logic              row_valid_q, row_valid_d;
  logic [3*COLS-1:0] row_bitmap_q, row_bitmap_d;
  logic [3*COLS-1:0] render_s;
  logic              shift_s, xfer_s, hit_s;

  function automatic logic [2:0] sprite_px(input logic [1:0] t, input logic [2:0] row,
                                           input logic [2:0] p);
    logic       border;
    logic       inner;
    logic [2:0] colour;
    border = 1'b0;
    inner  = 1'b0;
    case (row)
      3'd0, 3'd6: border = (p >= 3'd2) && (p <= 3'd4);
      3'd1, 3'd5: begin
        border = (p == 3'd1) || (p == 3'd5);
        inner  = (p >= 3'd2) && (p <= 3'd4);
      end
      3'd2, 3'd3, 3'd4: begin
        border = (p == 3'd0) || (p == 3'd6);
        inner  = (p >= 3'd1) && (p <= 3'd5);
      end
      default: begin
        border = 1'b0;
        inner  = 1'b0;
      end
    endcase
    case (t)
      2'b01:   colour = 3'b100;
      2'b10:   colour = 3'b011;
      2'b11:   colour = 3'b110;
      default: colour = 3'b000;
    endcase
    if (t == 2'b00)  return 3'b000;
    else if (border) return 3'b111;
    else if (inner)  return colour;
    else             return 3'b000;
  endfunction

  assign note_ready = !pend_v_q;
  assign judge_type = slot_q[0];
  assign hit_ack    = hit_ack_q;
  assign hit_type   = hit_type_q;
  assign miss_pulse = miss_q;
  assign row_valid  = row_valid_q;
  assign row_bitmap = row_bitmap_q;

  // Column c shows pixel (c + offset) of the lane, so the band slides left as offset grows.
  always_comb begin : render_blk
    int            x;
    logic [SW-1:0] s;
    logic [2:0]    p;
    render_s = '0;
    x = 0;
    s = '0;
    p = 3'd0;
    for (int c = 0; c < COLS; c++) begin
      x = c + int'(off_q);
      s = SW'(x / 7);
      p = 3'(x % 7);
      if (int'(s) < SLOTS) render_s[3*c +: 3] = sprite_px(slot_q[s], row_sel, p);
      else                 render_s[3*c +: 3] = 3'b000;
    end
  end

  always_comb begin
    shift_s = tick && (off_q == OFF_MAX);
    xfer_s  = note_valid && !pend_v_q;
    hit_s   = hit_valid && (slot_q[0] != 2'b00);

    if (tick) begin
      if (off_q == OFF_MAX) off_d = 3'd0;
      else                  off_d = off_q + 3'd1;
    end else begin
      off_d = off_q;
    end

    // A transfer only happens into an empty buffer, so it never races a consume.
    pend_v_d    = pend_v_q;
    pend_type_d = pend_type_q;
    if (xfer_s) begin
      pend_v_d    = 1'b1;
      pend_type_d = note_type;
    end else if (shift_s) begin
      pend_v_d    = 1'b0;
    end else begin
      pend_v_d    = pend_v_q;
    end

    for (int k = 0; k < SLOTS; k++) slot_d[k] = slot_q[k];
    if (shift_s) begin
      for (int k = 0; k < SLOTS - 1; k++) slot_d[k] = slot_q[k + 1];
      slot_d[SLOTS-1] = pend_v_q ? pend_type_q : 2'b00;
    end else if (hit_s) begin
      slot_d[0] = 2'b00;
    end else begin
      slot_d[0] = slot_q[0];
    end

    hit_ack_d    = hit_s;
    hit_type_d   = hit_s ? slot_q[0] : 2'b00;
    miss_d       = shift_s && (slot_q[0] != 2'b00) && !hit_s;
    row_valid_d  = row_req;
    row_bitmap_d = row_req ? render_s : row_bitmap_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SLOTS; k++) slot_q[k] <= 2'b00;
      off_q        <= 3'd0;
      pend_v_q     <= 1'b0;
      pend_type_q  <= 2'b00;
      hit_ack_q    <= 1'b0;
      hit_type_q   <= 2'b00;
      miss_q       <= 1'b0;
      row_valid_q  <= 1'b0;
      row_bitmap_q <= '0;
    end else begin
      for (int k = 0; k < SLOTS; k++) slot_q[k] <= slot_d[k];
      off_q        <= off_d;
      pend_v_q     <= pend_v_d;
      pend_type_q  <= pend_type_d;
      hit_ack_q    <= hit_ack_d;
      hit_type_q   <= hit_type_d;
      miss_q       <= miss_d;
      row_valid_q  <= row_valid_d;
      row_bitmap_q <= row_bitmap_d;
    end
  end

endmodule

// File: tb/tb_note_lane_scroller.sv
// Scoreboard bench for note_lane_scroller: stimulus queues expected pulses/rows,
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_note_lane_scroller;

  localparam int COLS = 64;
  localparam int W    = 3 * COLS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         tick = 1'b0;
  logic         note_valid = 1'b0;
  logic [1:0]   note_type = 2'b00;
  logic         note_ready;
  logic         hit_valid = 1'b0;
  logic         hit_ack;
  logic [1:0]   hit_type;
  logic         miss_pulse;
  logic [1:0]   judge_type;
  logic         row_req = 1'b0;
  logic [2:0]   row_sel = 3'd0;
  logic         row_valid;
  logic [W-1:0] row_bitmap;

  typedef struct {
    int           kind;
    logic [W-1:0] data;
  } evt_t;

  evt_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  note_lane_scroller #(.COLS(COLS), .SLOTS(10), .SW(4)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .note_valid(note_valid),
    .note_type(note_type), .note_ready(note_ready), .hit_valid(hit_valid),
    .hit_ack(hit_ack), .hit_type(hit_type), .miss_pulse(miss_pulse),
    .judge_type(judge_type), .row_req(row_req), .row_sel(row_sel),
    .row_valid(row_valid), .row_bitmap(row_bitmap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic mon(input string name, input int kind, input logic [W-1:0] act);
    evt_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: unexpected output %h with nothing expected", name, act);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data !== act)
        $display("FAIL %s: got kind %0d data %h expected kind %0d data %h",
                 name, kind, act, e.kind, e.data);
      else n_pass++;
    end
  endtask

  always @(negedge clk) begin
    if (row_valid === 1'b1)  mon("row", 0, row_bitmap);
    if (hit_ack === 1'b1)    mon("hit", 1, W'(hit_type));
    if (miss_pulse === 1'b1) mon("miss", 2, '0);
  end

  function automatic logic [W-1:0] px(input logic [W-1:0] v, input int c, input logic [2:0] val);
    v[3*c +: 3] = val;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic req_row(input logic [2:0] sel, input logic [W-1:0] exp);
    exp_q.push_back('{kind: 0, data: exp});
    row_req = 1'b1;
    row_sel = sel;
    step();
    row_req = 1'b0;
  endtask

  task automatic offer(input logic [1:0] t);
    note_valid = 1'b1;
    note_type  = t;
    step();
    note_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] v;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_row_valid", W'(row_valid), '0);
    chk("rst_row_bitmap", row_bitmap, '0);
    chk("rst_hit_ack", W'(hit_ack), '0);
    chk("rst_miss", W'(miss_pulse), '0);
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", W'(note_ready), W'(1'b1));
    chk("judge_after_rst", W'(judge_type), '0);
    req_row(3'd3, '0);

    // Red note into slot 9, then look at it at offsets 0 and 3.
    offer(2'b01);
    chk("ready_pend_full", W'(note_ready), '0);
    ticks(7);
    chk("ready_after_shift", W'(note_ready), W'(1'b1));
    v = px('0, 63, 3'b111);
    req_row(3'd3, v);
    req_row(3'd0, '0);
    req_row(3'd7, '0);
    ticks(3);
    v = px('0, 60, 3'b111); v = px(v, 61, 3'b100); v = px(v, 62, 3'b100); v = px(v, 63, 3'b100);
    req_row(3'd3, v);
    v = px('0, 61, 3'b111); v = px(v, 62, 3'b100); v = px(v, 63, 3'b100);
    req_row(3'd1, v);
    ticks(4);

    // Back-to-back blue then red: second waits for the shift that drains pend.
    note_valid = 1'b1;
    note_type  = 2'b10;
    step();
    note_type  = 2'b01;
    chk("ready_b2b", W'(note_ready), '0);
    ticks(7);
    step();
    note_valid = 1'b0;
    chk("ready_second_held", W'(note_ready), '0);
    ticks(7);
    chk("ready_after_2shift", W'(note_ready), W'(1'b1));
    v = px('0, 42, 3'b111);
    for (int c = 43; c <= 47; c++) v = px(v, c, 3'b100);
    v = px(v, 48, 3'b111);
    v = px(v, 56, 3'b111);
    for (int c = 57; c <= 61; c++) v = px(v, c, 3'b011);
    v = px(v, 62, 3'b111);
    v = px(v, 63, 3'b111);
    req_row(3'd3, v);

    // Red reaches the judge slot and is hit; a hit on an empty slot does nothing.
    ticks(42);
    chk("judge_red", W'(judge_type), W'(2'b01));
    exp_q.push_back('{kind: 1, data: W'(2'b01)});
    hit_valid = 1'b1;
    step();
    hit_valid = 1'b0;
    chk("judge_cleared", W'(judge_type), '0);
    hit_valid = 1'b1;
    step();
    hit_valid = 1'b0;
    ticks(7);

    // Blue scrolls out unhit.
    ticks(7);
    chk("judge_blue", W'(judge_type), W'(2'b10));
    exp_q.push_back('{kind: 2, data: '0});
    ticks(7);
    chk("judge_red2", W'(judge_type), W'(2'b01));

    // Gold queued; red hit on the wrapping tick counts as a hit, not a miss.
    offer(2'b11);
    ticks(6);
    exp_q.push_back('{kind: 1, data: W'(2'b01)});
    tick = 1'b1;
    hit_valid = 1'b1;
    step();
    tick = 1'b0;
    hit_valid = 1'b0;
    chk("judge_after_hitshift", W'(judge_type), '0);
    ticks(63);
    chk("judge_gold", W'(judge_type), W'(2'b11));
    ticks(3);
    v = px('0, 0, 3'b110); v = px(v, 1, 3'b110); v = px(v, 2, 3'b110); v = px(v, 3, 3'b111);
    req_row(3'd3, v);
    v = px('0, 0, 3'b111); v = px(v, 1, 3'b111);
    req_row(3'd6, v);
    ticks(3);
    // Render, hit and shift on one edge: render sees the pre-shift lane at offset 6.
    exp_q.push_back('{kind: 0, data: px('0, 0, 3'b111)});
    exp_q.push_back('{kind: 1, data: W'(2'b11)});
    tick = 1'b1;
    hit_valid = 1'b1;
    row_req = 1'b1;
    row_sel = 3'd3;
    step();
    tick = 1'b0;
    hit_valid = 1'b0;
    row_req = 1'b0;
    chk("judge_after_gold", W'(judge_type), '0);

    // Reset asserted mid-scroll with a render in flight and a note pending.
    offer(2'b01);
    ticks(7);
    ticks(2);
    offer(2'b10);
    row_req = 1'b1;
    row_sel = 3'd3;
    tick = 1'b1;
    @(posedge clk);
    #1;
    v = px('0, 61, 3'b111); v = px(v, 62, 3'b100); v = px(v, 63, 3'b100);
    chk("render_before_rst", row_bitmap, v);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_row_valid", W'(row_valid), '0);
    chk("arst_row_bitmap", row_bitmap, '0);
    chk("arst_hit_ack", W'(hit_ack), '0);
    chk("arst_hit_type", W'(hit_type), '0);
    chk("arst_miss", W'(miss_pulse), '0);
    chk("arst_judge", W'(judge_type), '0);
    chk("arst_ready", W'(note_ready), W'(1'b1));
    row_req = 1'b0;
    tick = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    req_row(3'd3, '0);
    chk("ready_final", W'(note_ready), W'(1'b1));

    repeat (3) step();
    chk("scoreboard_drained", W'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
